// File: rtl/input_stream_node.sv
// input_stream_node: strided OBI read master that streams read data out through a
// small valid/ready FIFO. The transfer walks row_count rows of row_size elements.
// Build option: define ISN_2D_EN for 2-D (row/column) addressing; without it the
// node runs a 1-D stream (row_count treated as 1, row_stride ignored).

typedef struct packed {
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
} obi_req_t;

typedef struct packed {
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
} obi_resp_t;

module input_stream_node #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              execute_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       elem_stride_i,
  input  logic [15:0]       row_size_i,
  input  logic [15:0]       row_stride_i,
  input  logic [15:0]       row_count_i,
  output obi_req_t          masters_req_o,
  input  obi_resp_t         masters_resp_i,
  output logic [31:0]       dout_o,
  output logic              dout_v_o,
  input  logic              dout_r_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StFlush, StDone} state_e;

  state_e state_q, state_d;

  // Latched transfer configuration
  logic [15:0]       elem_stride_q;
  logic [15:0]       row_size_q;
  logic [15:0]       row_stride_q;
  logic [15:0]       rows_q;

  // Address walk state
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [15:0]       col_q;
  logic [15:0]       row_q;

  // Read tracking and output FIFO
  logic [CntW-1:0]   outstanding_q;
  logic [31:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;

  logic [15:0]       rows_in;
  logic [15:0]       row_stride_in;
  logic [ADDR_W-1:0] elem_step;
  logic [ADDR_W-1:0] row_step;
  logic [ADDR_W-1:0] next_row_base;
  logic [31:0]       obi_addr;
  logic [CntW:0]     credit_used;
  logic              credit_ok;
  logic              req;
  logic              grant;
  logic              last_col;
  logic              last_elem;
  logic              start;
  logic              xfer_active;
  logic              flush;
  logic              push;
  logic              pop;
  logic              fifo_empty;

`ifdef ISN_2D_EN
  assign rows_in       = row_count_i;
  assign row_stride_in = row_stride_i;
`else
  // 1-D build: row controls are accepted on the ports but have no effect
  logic unused_row_cfg;
  assign unused_row_cfg = ^{row_count_i, row_stride_i};
  assign rows_in        = 16'd1;
  assign row_stride_in  = 16'd0;
`endif

  // Strides are signed byte offsets; sign-extend and let the adds wrap.
  assign elem_step     = ADDR_W'($signed(elem_stride_q));
  assign row_step      = ADDR_W'($signed(row_stride_q));
  assign next_row_base = row_base_q + row_step;

  generate
    if (ADDR_W >= 32) begin : g_addr_trunc
      assign obi_addr = cur_addr_q[31:0];
    end else begin : g_addr_ext
      assign obi_addr = {{(32 - ADDR_W){1'b0}}, cur_addr_q};
    end
  endgenerate

  assign last_col  = (col_q == row_size_q - 16'd1);
  assign last_elem = last_col && (row_q == rows_q - 16'd1);

  // Requests in flight plus buffered words may never exceed the FIFO size, so
  // every returning read is guaranteed a slot.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign credit_ok   = credit_used < (CntW + 1)'(FIFO_DEPTH);

  assign req   = (state_q == StRun) && credit_ok && !clear_i;
  assign grant = req && masters_resp_i.gnt;
  assign start = (state_q == StIdle) && execute_i && !clear_i;

  assign xfer_active = (state_q == StRun) || (state_q == StDrain);
  assign flush       = xfer_active && clear_i;
  // Only reads we actually issued are accepted; stray rvalids are dropped.
  assign push        = xfer_active && !clear_i && masters_resp_i.rvalid &&
                       (outstanding_q != '0);

  assign fifo_empty = (fifo_cnt_q == '0);
  assign dout_v_o   = !fifo_empty;
  assign dout_o     = fifo_mem_q[rd_ptr_q];
  assign pop        = dout_v_o && dout_r_i;

  assign busy_o = (state_q == StRun) || (state_q == StDrain) || (state_q == StFlush);
  assign done_o = (state_q == StDone);

  // OBI read request: byte enables all on, never a write
  always_comb begin
    masters_req_o      = '0;
    masters_req_o.req  = req;
    masters_req_o.addr = obi_addr;
    masters_req_o.be   = 4'hF;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (row_size_i == '0 || rows_in == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (clear_i) begin
          state_d = StFlush;
        end else if (grant && last_elem) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (clear_i) begin
          state_d = StFlush;
        end else if (outstanding_q == '0 && fifo_empty) begin
          state_d = StDone;
        end
      end
      StFlush: begin
        if (outstanding_q == '0) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        if (clear_i || !execute_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration latch and address walk; address only moves on a grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_stride_q <= '0;
      row_size_q    <= '0;
      row_stride_q  <= '0;
      rows_q        <= '0;
      row_base_q    <= '0;
      cur_addr_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
    end else if (start) begin
      elem_stride_q <= elem_stride_i;
      row_size_q    <= row_size_i;
      row_stride_q  <= row_stride_in;
      rows_q        <= rows_in;
      row_base_q    <= base_addr_i;
      cur_addr_q    <= base_addr_i;
      col_q         <= '0;
      row_q         <= '0;
    end else if (grant) begin
      if (last_col) begin
        col_q      <= '0;
        row_q      <= row_q + 16'd1;
        row_base_q <= next_row_base;
        cur_addr_q <= next_row_base;
      end else begin
        col_q      <= col_q + 16'd1;
        cur_addr_q <= cur_addr_q + elem_step;
      end
    end
  end

  // Outstanding read counter; a grant and a return in one cycle cancel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      case ({grant, masters_resp_i.rvalid && (outstanding_q != '0)})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // FIFO pointers and occupancy; an abort empties it at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (push) begin
      fifo_mem_q[wr_ptr_q] <= masters_resp_i.rdata;
    end
  end

endmodule

// File: tb/tb_input_stream_node.sv
// Directed bench for input_stream_node: table of transfers plus hand-written
// stall, abort and mid-transfer reset sequences. Follows ISN_2D_EN like the DUT.

module tb_input_stream_node;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned AddrW     = 32;

  logic        clk;
  logic        rst_n;
  logic        execute;
  logic        clear;
  logic [31:0] base;
  logic [15:0] elem_stride;
  logic [15:0] row_size;
  logic [15:0] row_stride;
  logic [15:0] row_count;
  obi_req_t    mreq;
  obi_resp_t   mresp;
  logic [31:0] dout;
  logic        dout_v;
  logic        dout_r;
  logic        busy;
  logic        done;

  // Memory model controls
  logic        gnt_en;
  logic        rvalid_en;
  logic        rvalid;
  logic [31:0] rdata;

  logic [31:0] pend_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] beat_log[$];

  int total;
  int bad;

  input_stream_node #(
    .FIFO_DEPTH(FifoDepth),
    .ADDR_W    (AddrW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .execute_i     (execute),
    .clear_i       (clear),
    .base_addr_i   (base),
    .elem_stride_i (elem_stride),
    .row_size_i    (row_size),
    .row_stride_i  (row_stride),
    .row_count_i   (row_count),
    .masters_req_o (mreq),
    .masters_resp_i(mresp),
    .dout_o        (dout),
    .dout_v_o      (dout_v),
    .dout_r_i      (dout_r),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb begin
    mresp        = '0;
    mresp.gnt    = mreq.req & gnt_en;
    mresp.rvalid = rvalid;
    mresp.rdata  = rdata;
  end

  // Memory slave: answers each granted read one cycle later, in order
  always @(negedge clk) begin
    if (rvalid_en && pend_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = data_of(pend_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    if (mreq.req && mresp.gnt) begin
      pend_q.push_back(mreq.addr);
      grant_log.push_back(mreq.addr);
    end
    if (dout_v && dout_r) beat_log.push_back(dout);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    check({name, " done"}, 32'(done), 32'd1);
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [15:0] es, input logic [15:0] rs,
                         input logic [15:0] rst, input logic [15:0] rc);
    base        = b;
    elem_stride = es;
    row_size    = rs;
    row_stride  = rst;
    row_count   = rc;
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [15:0] elem_stride;
    logic [15:0] row_size;
    logic [15:0] row_stride;
    logic [15:0] row_count;
    int          n;
    logic [31:0] addr [8];
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input int v);
    logic [31:0] got;
    grant_log.delete();
    beat_log.delete();
    set_cfg(vecs[v].base, vecs[v].elem_stride, vecs[v].row_size, vecs[v].row_stride,
            vecs[v].row_count);
    dout_r    = 1'b1;
    gnt_en    = 1'b1;
    rvalid_en = 1'b1;
    execute   = 1'b1;
    wait_done(vecs[v].name);
    check({vecs[v].name, " grants"}, 32'(grant_log.size()), 32'(vecs[v].n));
    check({vecs[v].name, " beats"}, 32'(beat_log.size()), 32'(vecs[v].n));
    for (int i = 0; i < vecs[v].n; i++) begin
      got = (i < grant_log.size()) ? grant_log[i] : 32'hxxxx_xxxx;
      check($sformatf("%s addr%0d", vecs[v].name, i), got, vecs[v].addr[i]);
      got = (i < beat_log.size()) ? beat_log[i] : 32'hxxxx_xxxx;
      check($sformatf("%s beat%0d", vecs[v].name, i), got, data_of(vecs[v].addr[i]));
    end
    check({vecs[v].name, " busy at done"}, 32'(busy), 32'd0);
    execute = 1'b0;
    tick();
    check({vecs[v].name, " back to idle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int          cyc;
    total = 0;
    bad   = 0;

    vecs[0] = '{"contig", 32'h1000, 16'd4, 16'd8, 16'd0, 16'd1, 8,
                '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                  32'h1010, 32'h1014, 32'h1018, 32'h101C}};
    vecs[2] = '{"neg_stride", 32'h10, 16'hFFFC, 16'd3, 16'd0, 16'd1, 3,
                '{32'h10, 32'h0C, 32'h08, 0, 0, 0, 0, 0}};
    vecs[4] = '{"addr_wrap", 32'hFFFF_FFFC, 16'd4, 16'd3, 16'd0, 16'd1, 3,
                '{32'hFFFF_FFFC, 32'h0, 32'h4, 0, 0, 0, 0, 0}};
`ifdef ISN_2D_EN
    vecs[1] = '{"two_rows", 32'h2000, 16'd4, 16'd3, 16'h0100, 16'd2, 6,
                '{32'h2000, 32'h2004, 32'h2008, 32'h2100, 32'h2104, 32'h2108, 0, 0}};
    vecs[3] = '{"neg_row", 32'h0, 16'd8, 16'd2, 16'hFFF0, 16'd2, 4,
                '{32'h0, 32'h8, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 0, 0, 0}};
`else
    vecs[1] = '{"two_rows", 32'h2000, 16'd4, 16'd3, 16'h0100, 16'd2, 3,
                '{32'h2000, 32'h2004, 32'h2008, 0, 0, 0, 0, 0}};
    vecs[3] = '{"neg_row", 32'h0, 16'd8, 16'd2, 16'hFFF0, 16'd2, 2,
                '{32'h0, 32'h8, 0, 0, 0, 0, 0, 0}};
`endif

    rst_n     = 1'b0;
    execute   = 1'b0;
    clear     = 1'b0;
    dout_r    = 1'b1;
    gnt_en    = 1'b1;
    rvalid_en = 1'b1;
    rvalid    = 1'b0;
    rdata     = '0;
    set_cfg(32'h0, 16'd0, 16'd0, 16'd0, 16'd0);

    // Reset state
    repeat (3) tick();
    check("reset req", 32'(mreq.req), 32'd0);
    check("reset dout_v", 32'(dout_v), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    // Empty row: straight to DONE, no bus activity
    grant_log.delete();
    set_cfg(32'h3000, 16'd4, 16'd0, 16'd0, 16'd1);
    execute = 1'b1;
    tick();
    check("zero_row done", 32'(done), 32'd1);
    check("zero_row busy", 32'(busy), 32'd0);
    check("zero_row req", 32'(mreq.req), 32'd0);
    execute = 1'b0;
    tick();
    check("zero_row grants", 32'(grant_log.size()), 32'd0);

    // Consumer stall: credit caps reads at the FIFO depth, head holds
    grant_log.delete();
    beat_log.delete();
    set_cfg(32'h4000, 16'd4, 16'd16, 16'd0, 16'd1);
    dout_r  = 1'b0;
    execute = 1'b1;
    repeat (20) tick();
    check("stall grants", 32'(grant_log.size()), 32'(FifoDepth));
    check("stall dout_v", 32'(dout_v), 32'd1);
    check("stall head", dout, data_of(32'h4000));
    repeat (5) tick();
    check("stall head hold", dout, data_of(32'h4000));
    check("stall grants hold", 32'(grant_log.size()), 32'(FifoDepth));
    dout_r = 1'b1;
    wait_done("stall");
    check("stall total grants", 32'(grant_log.size()), 32'd16);
    check("stall total beats", 32'(beat_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      got = (i < beat_log.size()) ? beat_log[i] : 32'hxxxx_xxxx;
      check($sformatf("stall beat%0d", i), got, data_of(32'h4000 + 32'(i * 4)));
    end
    execute = 1'b0;
    tick();

    // Abort with two reads outstanding
    grant_log.delete();
    beat_log.delete();
    set_cfg(32'h5000, 16'd4, 16'd8, 16'd0, 16'd1);
    rvalid_en = 1'b0;
    gnt_en    = 1'b1;
    execute   = 1'b1;
    repeat (3) tick();
    gnt_en  = 1'b0;
    clear   = 1'b1;
    execute = 1'b0;
    #1;
    check("clear req drop", 32'(mreq.req), 32'd0);
    tick();
    clear = 1'b0;
    check("clear grants", 32'(grant_log.size()), 32'd2);
    check("flush busy", 32'(busy), 32'd1);
    check("flush dout_v", 32'(dout_v), 32'd0);
    rvalid_en = 1'b1;
    gnt_en    = 1'b1;
    cyc = 0;
    while (busy && cyc < 50) begin
      tick();
      cyc++;
    end
    check("flush exit busy", 32'(busy), 32'd0);
    check("flush exit done", 32'(done), 32'd0);
    check("flush exit dout_v", 32'(dout_v), 32'd0);
    check("flush discarded", 32'(beat_log.size()), 32'd0);
    check("flush reads drained", 32'(pend_q.size()), 32'd0);

    // Reset mid-transfer, then late read data arriving in IDLE
    set_cfg(32'h6000, 16'd4, 16'd8, 16'd0, 16'd1);
    rvalid_en = 1'b0;
    execute   = 1'b1;
    repeat (3) tick();
    rst_n   = 1'b0;
    execute = 1'b0;
    #1;
    check("midreset req", 32'(mreq.req), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    tick();
    rst_n     = 1'b1;
    rvalid_en = 1'b1;
    beat_log.delete();
    repeat (5) tick();
    check("late rvalid dout_v", 32'(dout_v), 32'd0);
    check("late rvalid busy", 32'(busy), 32'd0);
    check("late rvalid beats", 32'(beat_log.size()), 32'd0);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
